// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the two handshake sides of the instruction encoder:
//     - field side : in_valid/in_ready handshake plus the decoded instruction
//                    fields (kind, rs, rt, rd, shamt, funct, imm)
//     - memory side: mem_we/mem_ready handshake plus write address and data
//
//   Modports
//     master : the producer of fields and consumer of memory writes
//              (drives in_* and mem_ready, observes in_ready and mem_*)
//     slave  : the encoder itself
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    // Field side
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;

    // Memory side
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns instruction fields (R-type, lw, sw, beq, addi) into 32-bit MIPS-style
//   words and writes them to consecutive word addresses of an instruction
//   memory. A small FIFO decouples the field producer from the memory.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      synchronous session restart: loads base_addr, flushes the
//                FIFO, clears count/wrapped/err; overrides every transfer
//     base_addr  first word address of a session
//     bus        instr_encoder_if.slave (field and memory handshakes)
//     count      words written this session, saturating at 2^ADDR_W
//     wrapped    sticky: write address rolled over from all-ones to zero
//     err        sticky: an illegal in_kind (5..7) was accepted
//
//   Field transfer : in_valid && in_ready
//   Memory transfer: mem_we && mem_ready
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              wrapped,
    output logic              err
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Field encoding (combinational at the input)
    // -------------------------------------------------------------------------
    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (kind)
            3'd0:    word = {6'h00, rs, rt, rd, shamt, funct};
            3'd1:    word = {6'h23, rs, rt, imm};
            3'd2:    word = {6'h2B, rs, rt, imm};
            3'd3:    word = {6'h04, rs, rt, imm};
            3'd4:    word = {6'h08, rs, rt, imm};
            default: word = '0;
        endcase
        return word;
    endfunction

    function automatic logic kind_legal(input logic [2:0] kind);
        return (kind <= 3'd4);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;
    state_t            state;
    logic              live;       // low until the first edge after reset
    logic [ADDR_W-1:0] addr;

    logic [31:0]       enc_word;
    logic              full;
    logic              in_fire;
    logic              push;
    logic              pop;

    assign enc_word = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                             bus.in_shamt, bus.in_funct, bus.in_imm);

    // in_ready depends only on registered state and start, never on mem_ready.
    assign full         = (occ == OCC_FULL);
    assign bus.in_ready = live && !full && !start;

    assign in_fire = bus.in_valid && bus.in_ready;
    assign push    = in_fire && kind_legal(bus.in_kind);
    assign pop     = bus.mem_we && bus.mem_ready;

    // mem_we is the FSM's registered WRITE state; it tracks "FIFO non-empty".
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_addr  = addr;
    // Masking the head with mem_we gives an all-zero data bus when empty,
    // so the storage itself needs no reset.
    assign bus.mem_wdata = bus.mem_we ? fifo_mem[rd_ptr] : 32'h0;

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + OCC_W'(1);
        end else if (!push && pop) begin
            occ_next = occ - OCC_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (data only, no reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    // -------------------------------------------------------------------------
    // Control: pointers, occupancy, output FSM, address/count/flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            state   <= S_IDLE;
            addr    <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            err     <= 1'b0;
        end else begin
            live <= 1'b1;
            if (start) begin
                // A write presented this cycle is discarded and not counted.
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
                state   <= S_IDLE;
                addr    <= base_addr;
                count   <= '0;
                wrapped <= 1'b0;
                err     <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    addr   <= addr + ADDR_W'(1);
                    if (count != CNT_MAX) begin
                        count <= count + (ADDR_W+1)'(1);
                    end
                    if (&addr) begin
                        wrapped <= 1'b1;
                    end
                end
                if (in_fire && !kind_legal(bus.in_kind)) begin
                    err <= 1'b1;
                end
                occ <= occ_next;

                case (state)
                    S_IDLE:  if (occ_next != '0) state <= S_WRITE;
                    S_WRITE: if (occ_next == '0) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
